// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_pkg
//  Brief    : Shared types, defaults and helpers for the CNN streaming blocks.
//  Revision : 1.0
// ============================================================================
package cnn_pkg;

    // Default image edge length in pixels (square images).
    localparam int DEFAULT_IMAGE_SIZE = 28;

    // Default pixel width. Blocks carry their own BitSize parameter and use
    // logic [BitSize-1:0] for pixels; pixel_t names the default-width form.
    localparam int DEFAULT_BIT_SIZE = 8;
    typedef logic [DEFAULT_BIT_SIZE-1:0] pixel_t;

    // Flat element index of window element (r,c) in an n-by-n window.
    function automatic int window_index(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_gen_if
//  Brief    : Pixel-in / window-out streaming bus of the window generator.
//  Revision : 1.0
// ============================================================================
interface conv_window_gen_if #(
    parameter int N       = 3,
    parameter int BitSize = 8
);
    logic                      in_valid;
    logic [BitSize-1:0]        in_data;
    logic                      out_valid;
    logic [BitSize*N*N-1:0]    out_data;
    logic                      out_last;

    // Pixel producer / window consumer side
    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    // Window generator side
    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data,
        output out_last
    );
endinterface
`default_nettype wire

// File: rtl/row_shift_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : row_shift_buffer
//  Brief    : Shift-register line buffer; d_out is d_in delayed by Depth
//             enabled shifts (one image row when Depth = image width).
//  Revision : 1.0
// ============================================================================
module row_shift_buffer
    import cnn_pkg::*;
#(
    parameter int BitSize = DEFAULT_BIT_SIZE,
    parameter int Depth   = DEFAULT_IMAGE_SIZE
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               shift_en,
    input  logic [BitSize-1:0] d_in,
    output logic [BitSize-1:0] d_out
);

    logic [BitSize-1:0] stage_q [Depth];

    // Advance the whole row by one position per accepted pixel
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            for (int i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else if (shift_en) begin
            stage_q[0] <= d_in;
            for (int i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign d_out = stage_q[Depth-1];

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_gen
//  Brief    : Raster-order pixel stream to stride-1 NxN sliding windows,
//             packed for direct connection to the dot-product stage.
//  Revision : 1.0
// ============================================================================
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int N         = 3,
    parameter int BitSize   = DEFAULT_BIT_SIZE,
    parameter int ImageSize = DEFAULT_IMAGE_SIZE
) (
    input  logic             clk,
    input  logic             res_n,
    conv_window_gen_if.slave bus
);

    localparam int            CW          = (ImageSize > 1) ? $clog2(ImageSize) : 1;
    localparam logic [CW-1:0] c_last_pos  = CW'(ImageSize - 1);
    localparam logic [CW-1:0] c_win_edge  = CW'(N - 1);

    logic [CW-1:0]      col_q, col_d;
    logic [CW-1:0]      row_q, row_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [BitSize-1:0] win_q [N][N];
    logic [BitSize-1:0] win_d [N][N];

    // taps_w[0] is the incoming pixel, taps_w[k] the pixel k rows above it
    logic [BitSize-1:0] taps_w [N];

    assign taps_w[0] = bus.in_data;

    generate
        for (genvar k = 0; k < N - 1; k++) begin : g_rowbuf
            row_shift_buffer #(
                .BitSize (BitSize),
                .Depth   (ImageSize)
            ) u_row_buf (
                .clk      (clk),
                .res_n    (res_n),
                .shift_en (bus.in_valid),
                .d_in     (taps_w[k]),
                .d_out    (taps_w[k+1])
            );
        end
    endgenerate

    // Position tracking and output flags; a window exists once the pixel is
    // at least N-1 rows and N-1 columns into the frame
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (bus.in_valid) begin
            out_valid_d = (row_q >= c_win_edge) && (col_q >= c_win_edge);
            out_last_d  = out_valid_d && (row_q == c_last_pos) && (col_q == c_last_pos);
            if (col_q == c_last_pos) begin
                col_d = '0;
                row_d = (row_q == c_last_pos) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Slide window left; new right column is oldest row on top, pixel at bottom
    always_comb begin
        win_d = win_q;
        if (bus.in_valid) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][N-1] = taps_w[N-1-r];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            win_q       <= win_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

    generate
        for (genvar r = 0; r < N; r++) begin : g_out_row
            for (genvar c = 0; c < N; c++) begin : g_out_col
                assign bus.out_data[window_index(r, c, N)*BitSize +: BitSize] = win_q[r][c];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_window_gen
//  Brief    : Scoreboard bench for conv_window_gen (N=3 and N=5, ImageSize=5).
//  Revision : 1.0
// ============================================================================
module tb_conv_window_gen;

    localparam int IS = 5;

    typedef struct {
        logic [199:0] data;
        logic         last;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic res_n = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    conv_window_gen_if #(.N(3), .BitSize(8)) ifa ();
    conv_window_gen_if #(.N(5), .BitSize(8)) ifb ();

    conv_window_gen #(.N(3), .BitSize(8), .ImageSize(IS)) dut_a (
        .clk   (clk),
        .res_n (res_n),
        .bus   (ifa)
    );

    conv_window_gen #(.N(5), .BitSize(8), .ImageSize(IS)) dut_b (
        .clk   (clk),
        .res_n (res_n),
        .bus   (ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: current frame image and next pixel position
    logic [7:0]  img [IS][IS];
    int          m_r = 0;
    int          m_c = 0;
    exp_t        qa[$];
    exp_t        qb[$];
    logic [71:0] log_a[$];
    int          wins_a = 0, lasts_a = 0, wins_b = 0, lasts_b = 0;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [199:0] build_win(input int n, input int r, input int c);
        logic [199:0] w;
        w = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                w[(i*n+j)*8 +: 8] = img[r-n+1+i][c-n+1+j];
        return w;
    endfunction

    // Independent formula: 3x3 window with top-left (r0,c0), pixel = base+row*5+col
    function automatic logic [71:0] pack_list(input int base, input int r0, input int c0);
        logic [71:0] w;
        int v;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                v = base + (r0 + i) * IS + c0 + j;
                w[(i*3+j)*8 +: 8] = v[7:0];
            end
        return w;
    endfunction

    task automatic idle();
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
        ifa.in_data  = 8'($urandom);
        ifb.in_data  = ifa.in_data;
        @(posedge clk); #1;
    endtask

    task automatic send_pixel(input int v);
        exp_t e;
        ifa.in_valid = 1'b1;
        ifb.in_valid = 1'b1;
        ifa.in_data  = v[7:0];
        ifb.in_data  = v[7:0];
        img[m_r][m_c] = v[7:0];
        if (m_r >= 2 && m_c >= 2) begin
            e.data = build_win(3, m_r, m_c);
            e.last = (m_r == IS-1) && (m_c == IS-1);
            e.cyc  = cyc + 1;
            qa.push_back(e);
        end
        if (m_r >= 4 && m_c >= 4) begin
            e.data = build_win(5, m_r, m_c);
            e.last = (m_r == IS-1) && (m_c == IS-1);
            e.cyc  = cyc + 1;
            qb.push_back(e);
        end
        if (m_c == IS-1) begin
            m_c = 0;
            m_r = (m_r == IS-1) ? 0 : m_r + 1;
        end else begin
            m_c = m_c + 1;
        end
        @(posedge clk); #1;
    endtask

    // Send pixels 0..n_pix-1 of a frame; duty in percent, optional forced gap
    task automatic frame(input int base, input int duty, input int n_pix, input int gap_at);
        int k;
        for (int p = 0; p < n_pix; p++) begin
            if (p == gap_at) idle();
            k = 0;
            while (duty < 100 && k < 8 && $urandom_range(0, 99) >= duty) begin
                idle();
                k++;
            end
            send_pixel(base + p);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid_a"}, 200'(ifa.out_valid), '0);
        chk({tag, "_last_a"},  200'(ifa.out_last),  '0);
        chk({tag, "_data_a"},  200'(ifa.out_data),  '0);
        chk({tag, "_valid_b"}, 200'(ifb.out_valid), '0);
        chk({tag, "_data_b"},  200'(ifb.out_data),  '0);
    endtask

    // Monitor: every cycle out_valid must match the scoreboard's due entry
    logic        gap_prev = 1'b0;
    logic        res_prev = 1'b0;
    logic [71:0] prev_a = '0;
    logic [199:0] prev_b = '0;

    always @(posedge clk) gap_prev <= !ifa.in_valid;

    always @(negedge clk) begin
        exp_t e;
        logic due;
        if (res_n && res_prev) begin
            due = (qa.size() > 0) && (qa[0].cyc == cyc);
            chk("valid_a", 200'(ifa.out_valid), 200'(due));
            if (due) begin
                e = qa.pop_front();
                if (ifa.out_valid) begin
                    chk("data_a", 200'(ifa.out_data), e.data);
                    chk("last_a", 200'(ifa.out_last), 200'(e.last));
                    log_a.push_back(ifa.out_data);
                    wins_a++;
                    if (ifa.out_last) lasts_a++;
                end
            end else begin
                chk("last_idle_a", 200'(ifa.out_last), '0);
            end
            due = (qb.size() > 0) && (qb[0].cyc == cyc);
            chk("valid_b", 200'(ifb.out_valid), 200'(due));
            if (due) begin
                e = qb.pop_front();
                if (ifb.out_valid) begin
                    chk("data_b", ifb.out_data, e.data);
                    chk("last_b", 200'(ifb.out_last), 200'(e.last));
                    wins_b++;
                    if (ifb.out_last) lasts_b++;
                end
            end
            if (gap_prev) begin
                chk("gap_hold_a", 200'(ifa.out_data), 200'(prev_a));
                chk("gap_hold_b", ifb.out_data, prev_b);
            end
        end
        res_prev = res_n;
        prev_a   = ifa.out_data;
        prev_b   = ifb.out_data;
    end

    initial begin
        int w0, l0, wb0, lb0;
        ifa.in_valid = 1'b0; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.in_data = '0;
        #2 res_n = 1'b0;
        #1 check_zero("reset");
        @(posedge clk); @(posedge clk); #1 res_n = 1'b1;
        idle(); idle();

        // Continuous frame
        w0 = wins_a; l0 = lasts_a; wb0 = wins_b; lb0 = lasts_b;
        frame(0, 100, 25, -1);
        idle(); idle();
        chk("cont_count_a", 200'(wins_a - w0), 200'(9));
        chk("cont_lasts_a", 200'(lasts_a - l0), 200'(1));
        chk("cont_count_b", 200'(wins_b - wb0), 200'(1));
        chk("cont_lasts_b", 200'(lasts_b - lb0), 200'(1));
        chk("cont_first", 200'(log_a[w0]), 200'(pack_list(0, 0, 0)));
        chk("cont_after17", 200'(log_a[w0+3]), 200'(pack_list(0, 1, 0)));
        chk("cont_lastwin", 200'(log_a[w0+8]), 200'(pack_list(0, 2, 2)));

        // Random gaps, forced gap between pixels 14 and 15
        w0 = wins_a; l0 = lasts_a;
        frame(0, 50, 25, 15);
        idle(); idle();
        chk("gap_count_a", 200'(wins_a - w0), 200'(9));
        chk("gap_lasts_a", 200'(lasts_a - l0), 200'(1));
        chk("gap_first", 200'(log_a[w0]), 200'(pack_list(0, 0, 0)));

        // Two back-to-back frames
        w0 = wins_a; l0 = lasts_a; wb0 = wins_b;
        frame(0, 100, 25, -1);
        frame(100, 100, 25, -1);
        idle(); idle();
        chk("b2b_count_a", 200'(wins_a - w0), 200'(18));
        chk("b2b_lasts_a", 200'(lasts_a - l0), 200'(2));
        chk("b2b_count_b", 200'(wins_b - wb0), 200'(2));
        chk("b2b_f2_first", 200'(log_a[w0+9]), 200'(pack_list(100, 0, 0)));

        // Mid-frame asynchronous reset after pixel 13
        frame(0, 100, 14, -1);
        @(negedge clk); #1;
        ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
        res_n = 1'b0;
        #1 check_zero("async_rst");
        qa.delete(); qb.delete();
        m_r = 0; m_c = 0;
        @(posedge clk); @(posedge clk); #1 res_n = 1'b1;
        w0 = wins_a; l0 = lasts_a;
        frame(0, 60, 25, -1);
        idle(); idle();
        chk("rst_count_a", 200'(wins_a - w0), 200'(9));
        chk("rst_lasts_a", 200'(lasts_a - l0), 200'(1));
        chk("rst_first", 200'(log_a[w0]), 200'(pack_list(0, 0, 0)));

        idle(); idle(); idle();
        chk("qa_drained", 200'(qa.size()), '0);
        chk("qb_drained", 200'(qb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
